// File: rtl/xp_fifo_diag_pkg.sv
// Shared op and state encodings for the xp_fifo diagnostic sequencer.
// Pure declarations: no latency and no flow control.
package xp_fifo_diag_pkg;

   localparam int XP_WIDTH       = 246;
   localparam int XP_ASZ         = 6;
   localparam int XP_PWIDTH      = 14;
   localparam int XP_QUIESCE_CYC = 4;
   localparam int XP_TMO_CYC     = 255;

   localparam logic [1:0] OP_RD_ENTRY = 2'd0;
   localparam logic [1:0] OP_WR_ENTRY = 2'd1;
   localparam logic [1:0] OP_RD_PTR   = 2'd2;
   localparam logic [1:0] OP_WR_PTR   = 2'd3;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FREEZE = 3'd1;
   localparam logic [2:0] ISSUE  = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] RESP   = 3'd4;

   // One-hot request vector, bit position equals the op code.
   function automatic logic [3:0] op_req(input logic [1:0] op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/xp_diag_cnt.sv
// Loadable down-counter with zero flag. Load/decrement take effect next cycle;
// it saturates at zero and has no flow control.
module xp_diag_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/xp_fifo_diag_ctl.sv
// Diag sequencer for xp_fifo: freeze traffic, run one cfg/pointer req/ack access, return one response.
// Accept-to-rsp latency is quiesce_cyc+2+ack cycles (2+ack while held); one command in flight, rsp held until rsp_drdy.
module xp_fifo_diag_ctl
   import xp_fifo_diag_pkg::*;
#(
   parameter int width       = XP_WIDTH,
   parameter int asz         = XP_ASZ,
   parameter int pwidth      = XP_PWIDTH,
   parameter int quiesce_cyc = XP_QUIESCE_CYC,
   parameter int tmo_cyc     = XP_TMO_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_srdy,
   output logic              cmd_drdy,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_hold,
   input  logic [asz-1:0]    cmd_addr,
   input  logic [width-1:0]  cmd_data,
   output logic              rsp_srdy,
   input  logic              rsp_drdy,
   output logic [width-1:0]  rsp_data,
   output logic              rsp_err,
   output logic              enqEn,
   output logic              deqEn,
   output logic [asz-1:0]    cfg_addr,
   output logic              cfg_rd_req,
   output logic              cfg_wr_req,
   output logic [width-1:0]  cfg_wr_data,
   input  logic              cfg_rd_ack,
   input  logic [width-1:0]  cfg_rd_data,
   input  logic              cfg_wr_ack,
   output logic              fifo_ptr_rd_req,
   input  logic              fifo_ptr_rd_ack,
   input  logic [pwidth-1:0] fifo_ptr_rd_data,
   output logic              fifo_ptr_wr_req,
   input  logic              fifo_ptr_wr_ack,
   output logic [pwidth-1:0] fifo_ptr_wr_data,
   output logic              frozen
);

   localparam logic [7:0] QUIESCE_LD = 8'(quiesce_cyc - 1);
   localparam logic [7:0] TMO_LD     = 8'(tmo_cyc - 1);

   logic [2:0]        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic              hold_cmd_q, hold_cmd_d;
   logic              hold_q, hold_d;
   logic              ack_pend_q, ack_pend_d;
   logic [3:0]        req_q, req_d;
   logic              cmd_drdy_q, cmd_drdy_d;
   logic              rsp_srdy_q, rsp_srdy_d;
   logic              rsp_err_q, rsp_err_d;
   logic              en_q, en_d;
   logic              frozen_q, frozen_d;
   logic [width-1:0]  rsp_data_q, rsp_data_d;
   logic [width-1:0]  wr_data_q, wr_data_d;
   logic [asz-1:0]    addr_q, addr_d;
   logic [pwidth-1:0] ptr_wr_q, ptr_wr_d;
   logic [width-1:0]  rd_sel;
   logic              ack_match;
   logic              qz_load, qz_dec, qz_zero;
   logic              tmo_load, tmo_dec, tmo_zero;

   xp_diag_cnt #(.W(8)) u_quiesce (
      .clk        (clk),
      .reset      (reset),
      .load_i     (qz_load),
      .load_val_i (QUIESCE_LD),
      .dec_i      (qz_dec),
      .zero_o     (qz_zero)
   );

   xp_diag_cnt #(.W(8)) u_tmo (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmo_load),
      .load_val_i (TMO_LD),
      .dec_i      (tmo_dec),
      .zero_o     (tmo_zero)
   );

   always_comb begin
      ack_match = 1'b0;
      rd_sel    = '0;
      case (op_q)
         OP_RD_ENTRY: begin
            ack_match = cfg_rd_ack;
            rd_sel    = cfg_rd_data;
         end
         OP_WR_ENTRY: ack_match = cfg_wr_ack;
         OP_RD_PTR: begin
            ack_match = fifo_ptr_rd_ack;
            rd_sel    = {{(width-pwidth){1'b0}}, fifo_ptr_rd_data};
         end
         default:     ack_match = fifo_ptr_wr_ack;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      hold_cmd_d = hold_cmd_q;
      hold_d     = hold_q;
      ack_pend_d = ack_pend_q;
      req_d      = req_q;
      cmd_drdy_d = cmd_drdy_q;
      rsp_srdy_d = rsp_srdy_q;
      rsp_err_d  = rsp_err_q;
      rsp_data_d = rsp_data_q;
      en_d       = en_q;
      frozen_d   = frozen_q;
      addr_d     = addr_q;
      wr_data_d  = wr_data_q;
      ptr_wr_d   = ptr_wr_q;
      qz_load    = 1'b0;
      qz_dec     = 1'b0;
      tmo_load   = 1'b0;
      tmo_dec    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_drdy_d = 1'b1;
            if (cmd_drdy_q && cmd_srdy) begin
               op_d       = cmd_op;
               hold_cmd_d = cmd_hold;
               addr_d     = cmd_addr;
               if (cmd_op == OP_WR_ENTRY) wr_data_d = cmd_data;
               if (cmd_op == OP_WR_PTR)   ptr_wr_d  = cmd_data[pwidth-1:0];
               cmd_drdy_d = 1'b0;
               // Traffic is already frozen by a previous held command: skip quiesce.
               if (hold_q) begin
                  state_d = ISSUE;
                  req_d   = op_req(cmd_op);
               end else begin
                  state_d  = FREEZE;
                  en_d     = 1'b0;
                  frozen_d = 1'b1;
                  qz_load  = 1'b1;
               end
            end
         end
         FREEZE: begin
            if (qz_zero) begin
               state_d = ISSUE;
               req_d   = op_req(op_q);
            end else begin
               qz_dec = 1'b1;
            end
         end
         ISSUE: begin
            tmo_load = 1'b1;
            state_d  = WAIT;
            // An ack coincident with the rising req is remembered so WAIT lasts one cycle.
            if (ack_match) begin
               ack_pend_d = 1'b1;
               rsp_data_d = rd_sel;
            end
         end
         WAIT: begin
            if (ack_pend_q || ack_match || tmo_zero) begin
               req_d      = '0;
               rsp_srdy_d = 1'b1;
               ack_pend_d = 1'b0;
               rsp_err_d  = !(ack_pend_q || ack_match);
               state_d    = RESP;
               if (!ack_pend_q) rsp_data_d = ack_match ? rd_sel : '0;
            end else begin
               tmo_dec = 1'b1;
            end
         end
         RESP: begin
            if (rsp_drdy) begin
               rsp_srdy_d = 1'b0;
               hold_d     = hold_cmd_q;
               cmd_drdy_d = 1'b1;
               state_d    = IDLE;
               if (!hold_cmd_q) begin
                  en_d     = 1'b1;
                  frozen_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= OP_RD_ENTRY;
         hold_cmd_q <= 1'b0;
         hold_q     <= 1'b0;
         ack_pend_q <= 1'b0;
         req_q      <= '0;
         cmd_drdy_q <= 1'b0;
         rsp_srdy_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
         en_q       <= 1'b1;
         frozen_q   <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         ptr_wr_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         hold_cmd_q <= hold_cmd_d;
         hold_q     <= hold_d;
         ack_pend_q <= ack_pend_d;
         req_q      <= req_d;
         cmd_drdy_q <= cmd_drdy_d;
         rsp_srdy_q <= rsp_srdy_d;
         rsp_err_q  <= rsp_err_d;
         rsp_data_q <= rsp_data_d;
         en_q       <= en_d;
         frozen_q   <= frozen_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         ptr_wr_q   <= ptr_wr_d;
      end
   end

   assign cmd_drdy         = cmd_drdy_q;
   assign rsp_srdy         = rsp_srdy_q;
   assign rsp_data         = rsp_data_q;
   assign rsp_err          = rsp_err_q;
   assign enqEn            = en_q;
   assign deqEn            = en_q;
   assign frozen           = frozen_q;
   assign cfg_addr         = addr_q;
   assign cfg_wr_data      = wr_data_q;
   assign fifo_ptr_wr_data = ptr_wr_q;
   assign cfg_rd_req       = req_q[OP_RD_ENTRY];
   assign cfg_wr_req       = req_q[OP_WR_ENTRY];
   assign fifo_ptr_rd_req  = req_q[OP_RD_PTR];
   assign fifo_ptr_wr_req  = req_q[OP_WR_PTR];

endmodule

// File: tb/tb_xp_fifo_diag_ctl.sv
// Bench for xp_fifo_diag_ctl: directed and random diag commands against a FIFO/pointer
// slave model and a reference memory predicting data, error, latency and freeze windows.
module tb_xp_fifo_diag_ctl;
   import xp_fifo_diag_pkg::*;

   localparam int W = 246;
   localparam int A = 6;
   localparam int P = 14;
   localparam int Q = 4;
   localparam int T = 255;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_srdy, cmd_drdy, cmd_hold;
   logic [1:0]   cmd_op;
   logic [A-1:0] cmd_addr;
   logic [W-1:0] cmd_data;
   logic         rsp_srdy, rsp_drdy, rsp_err;
   logic [W-1:0] rsp_data;
   logic         enqEn, deqEn, frozen;
   logic [A-1:0] cfg_addr;
   logic         cfg_rd_req, cfg_wr_req, cfg_rd_ack, cfg_wr_ack;
   logic [W-1:0] cfg_wr_data, cfg_rd_data;
   logic         fifo_ptr_rd_req, fifo_ptr_rd_ack, fifo_ptr_wr_req, fifo_ptr_wr_ack;
   logic [P-1:0] fifo_ptr_rd_data, fifo_ptr_wr_data;

   xp_fifo_diag_ctl dut (
      .clk(clk), .reset(reset),
      .cmd_srdy(cmd_srdy), .cmd_drdy(cmd_drdy), .cmd_op(cmd_op), .cmd_hold(cmd_hold),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_srdy(rsp_srdy), .rsp_drdy(rsp_drdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .enqEn(enqEn), .deqEn(deqEn),
      .cfg_addr(cfg_addr), .cfg_rd_req(cfg_rd_req), .cfg_wr_req(cfg_wr_req),
      .cfg_wr_data(cfg_wr_data), .cfg_rd_ack(cfg_rd_ack), .cfg_rd_data(cfg_rd_data),
      .cfg_wr_ack(cfg_wr_ack),
      .fifo_ptr_rd_req(fifo_ptr_rd_req), .fifo_ptr_rd_ack(fifo_ptr_rd_ack),
      .fifo_ptr_rd_data(fifo_ptr_rd_data), .fifo_ptr_wr_req(fifo_ptr_wr_req),
      .fifo_ptr_wr_ack(fifo_ptr_wr_ack), .fifo_ptr_wr_data(fifo_ptr_wr_data),
      .frozen(frozen)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] fifo_mem [64];
   logic [W-1:0] ref_mem  [64];
   logic [P-1:0] fifo_ptr, ref_ptr;
   logic         ref_hold;
   int           ack_dly, rsp_dly, req_age, req_len, rsp_age, low_cnt;
   bit           spur_en;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_w();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v[W-1:0];
   endfunction

   // One clock: sample outputs 1 time unit after the edge, then play the slave and response sink.
   task automatic step();
      logic [3:0] rv;
      @(posedge clk);
      #1;
      rv = {fifo_ptr_wr_req, fifo_ptr_rd_req, cfg_wr_req, cfg_rd_req};
      check_eq("req_onehot", 256'($countones(rv) <= 1), 256'(1));
      check_eq("no_req_idle", 256'(cmd_drdy && rv != 4'd0), 256'(0));
      check_eq("en_consistent", 256'((enqEn == deqEn) && (frozen == !enqEn)), 256'(1));
      if (!enqEn) low_cnt++;
      cfg_rd_ack = 1'b0;
      cfg_wr_ack = 1'b0;
      fifo_ptr_rd_ack = 1'b0;
      fifo_ptr_wr_ack = 1'b0;
      if (rv != 4'd0) begin
         req_age++;
         if (req_age == ack_dly) begin
            if (cfg_rd_req) begin cfg_rd_ack = 1'b1; cfg_rd_data = fifo_mem[cfg_addr]; end
            if (cfg_wr_req) begin cfg_wr_ack = 1'b1; fifo_mem[cfg_addr] = cfg_wr_data; end
            if (fifo_ptr_rd_req) begin fifo_ptr_rd_ack = 1'b1; fifo_ptr_rd_data = fifo_ptr; end
            if (fifo_ptr_wr_req) begin fifo_ptr_wr_ack = 1'b1; fifo_ptr = fifo_ptr_wr_data; end
         end
         if (spur_en && cfg_rd_req && req_age == 2) cfg_wr_ack = 1'b1;
      end else if (req_age != 0) begin
         req_len = req_age;
         req_age = 0;
      end
      if (rsp_srdy) begin
         rsp_drdy = (rsp_age >= rsp_dly);
         rsp_age++;
      end else begin
         rsp_drdy = 1'b0;
         rsp_age  = 0;
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [A-1:0] addr, input logic [W-1:0] data,
                         input logic hold, input int adly, input int rdly);
      logic [W-1:0] exp_d;
      logic         exp_e, held_in, xfer;
      int           w, exp_lat, lat, n;
      held_in = ref_hold;
      // The slave acks on its adly-th req-high cycle (1 = the issue cycle); WAIT lasts at least one
      // cycle and gives up after T cycles.
      if (adly == 0 || adly - 1 > T) begin
         w = T; exp_e = 1'b1;
      end else begin
         w = (adly <= 2) ? 1 : adly - 1; exp_e = 1'b0;
      end
      exp_d = '0;
      if (!exp_e) begin
         case (op)
            OP_RD_ENTRY: exp_d = ref_mem[addr];
            OP_WR_ENTRY: ref_mem[addr] = data;
            OP_RD_PTR:   exp_d = {{(W-P){1'b0}}, ref_ptr};
            default:     ref_ptr = data[P-1:0];
         endcase
      end
      exp_lat  = (held_in ? 0 : Q) + 2 + w;
      ref_hold = hold;
      ack_dly  = adly;
      rsp_dly  = rdly;
      req_len  = -1;
      cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_hold = hold; cmd_srdy = 1'b1;
      n = 0;
      while (!cmd_drdy && n < 20) begin step(); n++; end
      check_eq("cmd_accept", 256'(cmd_drdy), 256'(1));
      low_cnt = 0;
      step();
      lat = 1;
      cmd_srdy = 1'b0;
      cmd_data = rnd_w();
      while (!rsp_srdy && lat < 700) begin step(); lat++; end
      check_eq("rsp_latency", 256'(lat), 256'(exp_lat));
      n = 0;
      xfer = 1'b0;
      while (rsp_srdy && !xfer && n < 50) begin
         check_eq("rsp_data", 256'(rsp_data), 256'(exp_d));
         check_eq("rsp_err", 256'(rsp_err), 256'(exp_e));
         check_eq("cmd_drdy_busy", 256'(cmd_drdy), 256'(0));
         xfer = rsp_drdy;
         step();
         n++;
      end
      check_eq("rsp_transfer", 256'(xfer), 256'(1));
      check_eq("rsp_srdy_after", 256'(rsp_srdy), 256'(0));
      check_eq("enq_after", 256'(enqEn), 256'(!hold));
      check_eq("frozen_after", 256'(frozen), 256'(hold));
      check_eq("cmd_drdy_after", 256'(cmd_drdy), 256'(1));
      check_eq("req_high_cycles", 256'(req_len), 256'(1 + w));
      if (!held_in && !hold)
         check_eq("enq_low_cycles", 256'(low_cnt), 256'(Q + 1 + w + rdly + 1));
   endtask

   initial begin
      int n;
      reset = 1'b1;
      cmd_srdy = 1'b0; cmd_op = 2'd0; cmd_hold = 1'b0; cmd_addr = '0; cmd_data = '0;
      rsp_drdy = 1'b0;
      cfg_rd_ack = 1'b0; cfg_wr_ack = 1'b0; cfg_rd_data = '0;
      fifo_ptr_rd_ack = 1'b0; fifo_ptr_wr_ack = 1'b0; fifo_ptr_rd_data = '0;
      for (int i = 0; i < 64; i++) begin fifo_mem[i] = '0; ref_mem[i] = '0; end
      fifo_ptr = 14'h0A05; ref_ptr = 14'h0A05; ref_hold = 1'b0;
      ack_dly = 0; rsp_dly = 0; req_age = 0; req_len = -1; rsp_age = 0; low_cnt = 0; spur_en = 1'b0;

      repeat (3) step();
      check_eq("rst_enq", 256'({enqEn, deqEn}), 256'(2'b11));
      check_eq("rst_frozen", 256'(frozen), 256'(0));
      check_eq("rst_cmd_drdy", 256'(cmd_drdy), 256'(0));
      check_eq("rst_rsp", 256'({rsp_srdy, rsp_err}), 256'(0));
      check_eq("rst_rsp_data", 256'(rsp_data), 256'(0));
      check_eq("rst_cfg_out", 256'({cfg_addr, cfg_wr_data, fifo_ptr_wr_data}), 256'(0));
      reset = 1'b0;
      step();
      check_eq("post_rst_drdy", 256'(cmd_drdy), 256'(1));
      check_eq("post_rst_enq", 256'(enqEn), 256'(1));
      check_eq("post_rst_rsp", 256'(rsp_srdy), 256'(0));

      do_cmd(OP_WR_ENTRY, 6'h05, 246'h1234, 1'b0, 2, 1);
      do_cmd(OP_RD_ENTRY, 6'h05, rnd_w(), 1'b0, 2, 1);
      do_cmd(OP_RD_ENTRY, 6'h05, rnd_w(), 1'b0, 1, 0);

      do_cmd(OP_RD_PTR, 6'h00, rnd_w(), 1'b1, 2, 0);
      do_cmd(OP_WR_PTR, 6'h00, '0, 1'b0, 2, 0);
      do_cmd(OP_RD_PTR, 6'h00, rnd_w(), 1'b0, 3, 0);

      do_cmd(OP_RD_ENTRY, 6'h05, rnd_w(), 1'b0, 0, 0);
      do_cmd(OP_RD_ENTRY, 6'h05, rnd_w(), 1'b0, 256, 0);
      do_cmd(OP_WR_ENTRY, 6'h05, rnd_w(), 1'b0, 257, 0);

      spur_en = 1'b1;
      do_cmd(OP_RD_ENTRY, 6'h05, rnd_w(), 1'b0, 5, 10);
      spur_en = 1'b0;

      for (int i = 0; i < 40; i++) begin
         logic [1:0] rop;
         int         radly;
         rop   = 2'($urandom_range(0, 3));
         radly = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
         do_cmd(rop, 6'($urandom_range(0, 7)), rnd_w(), ($urandom_range(0, 3) == 0),
                radly, int'($urandom_range(0, 3)));
      end

      // Reset while a write request is outstanding in WAIT.
      ack_dly = 0;
      cmd_op = OP_WR_ENTRY; cmd_addr = 6'h03; cmd_data = rnd_w(); cmd_hold = 1'b0;
      cmd_srdy = 1'b1;
      n = 0;
      while (!cmd_drdy && n < 20) begin step(); n++; end
      step();
      cmd_srdy = 1'b0;
      n = 0;
      while (!(cfg_wr_req && req_age >= 3) && n < 30) begin step(); n++; end
      check_eq("rst_wait_req_hi", 256'(cfg_wr_req), 256'(1));
      reset = 1'b1;
      step();
      check_eq("rst_wait_reqs", 256'({cfg_rd_req, cfg_wr_req, fifo_ptr_rd_req, fifo_ptr_wr_req}), 256'(0));
      check_eq("rst_wait_enq", 256'(enqEn), 256'(1));
      check_eq("rst_wait_frozen", 256'(frozen), 256'(0));
      reset = 1'b0;
      ref_hold = 1'b0;
      step();
      check_eq("rst_wait_idle", 256'(cmd_drdy), 256'(1));
      for (int i = 0; i < 5; i++) begin
         check_eq("rst_wait_no_rsp", 256'(rsp_srdy), 256'(0));
         step();
      end
      do_cmd(OP_RD_ENTRY, 6'h03, rnd_w(), 1'b0, 2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog sim_time=%0t limit=900000 total=%0d bad=%0d", $time, total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/xp_fifo_diag_ctl.md
Name: xp_fifo_diag_ctl

Overview:
Sequencer for the diagnostic side-ports of the 64x246 xp_fifo (cfg entry access and pointer access). Accepts diag commands on an srdy/drdy channel, freezes FIFO traffic via enqEn/deqEn, and drives the cfg or pointer req/ack handshake. Returns one response per command. Sits between the chip CSR block and xp_fifo, and replaces the constant tie-offs used in the datapath benches.

Parameters:
width, 246, FIFO entry width
asz, 6, cfg address width (depth 64)
pwidth, 14, pointer word width ({rd_ptr[6:0], wr_ptr[6:0]})
quiesce_cyc, 4, cycles to wait after freeze before first access
tmo_cyc, 255, ack timeout in cycles, 8-bit counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_srdy  in  1  command valid
cmd_drdy  out  1  command accept
cmd_op  in  2  0=RD_ENTRY 1=WR_ENTRY 2=RD_PTR 3=WR_PTR
cmd_hold  in  1  keep traffic frozen after this command
cmd_addr  in  asz  entry address
cmd_data  in  width  write data; [pwidth-1:0] for WR_PTR
rsp_srdy  out  1  response valid
rsp_drdy  in  1  response accept
rsp_data  out  width  read data, zero-extended for RD_PTR, 0 for writes
rsp_err  out  1  ack timeout occurred
enqEn  out  1  FIFO enqueue enable
deqEn  out  1  FIFO dequeue enable
cfg_addr  out  asz  entry address
cfg_rd_req  out  1  entry read request
cfg_wr_req  out  1  entry write request
cfg_wr_data  out  width  entry write data
cfg_rd_ack  in  1  entry read done
cfg_rd_data  in  width  entry read data
cfg_wr_ack  in  1  entry write done
fifo_ptr_rd_req  out  1  pointer read request
fifo_ptr_rd_ack  in  1  pointer read done
fifo_ptr_rd_data  in  pwidth  pointer read data
fifo_ptr_wr_req  out  1  pointer write request
fifo_ptr_wr_ack  in  1  pointer write done
fifo_ptr_wr_data  out  pwidth  pointer write data
frozen  out  1  enqEn/deqEn currently deasserted

Behaviour:
- Reset values: enqEn=deqEn=1, all req=0, cmd_drdy=0, rsp_srdy=0, rsp_data=0, rsp_err=0, cfg_addr=0, cfg_wr_data=0, fifo_ptr_wr_data=0, frozen=0, state IDLE, hold flag 0.
- All outputs are registered. Reset in any state returns to IDLE next cycle, drops any outstanding req, and discards any pending response.
- States:
  - IDLE: cmd_drdy=1. On cmd_srdy, capture op/addr/data/hold. If already frozen (hold flag set), go to ISSUE. Otherwise go to FREEZE.
  - FREEZE: enqEn=deqEn=0, frozen=1. Wait quiesce_cyc cycles (counter loaded with quiesce_cyc-1), then go to ISSUE.
  - ISSUE: assert exactly one req selected by op; cfg_addr and write data are stable from this cycle. Go to WAIT.
  - WAIT: hold req high until the matching ack is sampled high. On ack: drop req next cycle, latch read data, go to RESP.
    - A non-matching ack is ignored.
    - If no ack arrives within tmo_cyc cycles: drop req, rsp_err=1, rsp_data=0, go to RESP.
  - RESP: rsp_srdy=1, with data and err stable until rsp_drdy. On transfer: hold flag := captured cmd_hold. If hold=0, enqEn=deqEn=1 and frozen=0 in the next cycle. Go to IDLE.
- Exactly one req is high at any time, never in IDLE.
- An ack arriving in the same cycle as req first rises is legal: latency is 1 cycle of WAIT.
- Nominal command latency, unfrozen, ack in 1 cycle: accept + quiesce_cyc + 3 cycles to rsp_srdy.
- Timeout counter width 8; tmo_cyc=0 is illegal.
- cmd_drdy=0 in every state except IDLE, so no command is queued behind an outstanding one.

Decomposition:
- Package xp_fifo_diag_pkg: op encoding constants (OP_RD_ENTRY..OP_WR_PTR) and the state encoding (IDLE, FREEZE, ISSUE, WAIT, RESP).
- One sub-module, xp_diag_cnt: a loadable down-counter with a zero flag, instanced twice (quiesce and timeout).
- The FSM stays in the top.

Test Plan:
- After reset: enqEn=deqEn=1, rsp_srdy=0, cmd_drdy=1 on the first post-reset cycle.
- Write then read: WR_ENTRY addr 6'h05 data 246'h1234, then RD_ENTRY addr 6'h05 against a memory model → rsp_data=246'h1234, rsp_err=0. enqEn low for quiesce_cyc+4 cycles each and high between the two commands.
- Hold sequence: RD_PTR with cmd_hold=1 (model returns 14'h0A05), then WR_PTR data 14'h0000 with hold=0.
  - rsp_data[13:0]=14'h0A05.
  - frozen stays 1 across both commands, with no second FREEZE phase.
  - enqEn returns to 1 one cycle after the second response transfer.
- Timeout: model never acks RD_ENTRY → req drops after 255 WAIT cycles; rsp_err=1, rsp_data=0; traffic re-enabled.
- Backpressure and spurious acks: rsp_drdy held low for 10 cycles → rsp_srdy and data stay stable, cmd_drdy=0. A cfg_wr_ack pulse during RD_ENTRY WAIT is ignored.
- Reset mid-WAIT: assert reset with cfg_wr_req high → next cycle all req=0, enqEn=1, state IDLE, and no response is emitted.
